// File: rtl/enc8b10b_lane.sv
// Pipelined multi-octet 8b/10b encoder with running-disparity chaining.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   i_valid          input word valid
//   i_data, i_k      OCTETS octets (octet 0 first on the wire) and per-octet K flags
//   i_rd_load        override the RD chain start for this word with i_rd_value
//   o_valid          output word valid, two clocks after i_valid
//   o_data           OCTETS 10-bit symbols, each ordered abcdeifghj (a = MSB)
//   o_k_error        per-octet flag: K requested for a non-K octet value
//   o_rd             running disparity after the last emitted symbol
module enc8b10b_lane #(
    parameter int unsigned OCTETS  = 4,
    parameter bit          RD_INIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [8*OCTETS-1:0]   i_data,
    input  logic [OCTETS-1:0]     i_k,
    input  logic                  i_rd_load,
    input  logic                  i_rd_value,
    output logic                  o_valid,
    output logic [10*OCTETS-1:0]  o_data,
    output logic [OCTETS-1:0]     o_k_error,
    output logic                  o_rd
);

    localparam int unsigned DW = 8 * OCTETS;
    localparam int unsigned SW = 10 * OCTETS;

    // 5b/6b code (abcdei) for RD-.
    function automatic logic [5:0] code6_rdm(input logic [4:0] x);
        case (x)
            5'd0:  return 6'b100111;  5'd1:  return 6'b011101;
            5'd2:  return 6'b101101;  5'd3:  return 6'b110001;
            5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
            5'd6:  return 6'b011001;  5'd7:  return 6'b111000;
            5'd8:  return 6'b111001;  5'd9:  return 6'b100101;
            5'd10: return 6'b010101;  5'd11: return 6'b110100;
            5'd12: return 6'b001101;  5'd13: return 6'b101100;
            5'd14: return 6'b011100;  5'd15: return 6'b010111;
            5'd16: return 6'b011011;  5'd17: return 6'b100011;
            5'd18: return 6'b010011;  5'd19: return 6'b110010;
            5'd20: return 6'b001011;  5'd21: return 6'b101010;
            5'd22: return 6'b011010;  5'd23: return 6'b111010;
            5'd24: return 6'b110011;  5'd25: return 6'b100110;
            5'd26: return 6'b010110;  5'd27: return 6'b110110;
            5'd28: return 6'b001110;  5'd29: return 6'b101110;
            5'd30: return 6'b011110;  default: return 6'b101011;
        endcase
    endfunction

    // 3b/4b data code (fghj) for RD- after the 6b sub-block (P7 for y=7).
    function automatic logic [3:0] code4d_rdm(input logic [2:0] y);
        case (y)
            3'd0: return 4'b1011;  3'd1: return 4'b1001;
            3'd2: return 4'b0101;  3'd3: return 4'b1100;
            3'd4: return 4'b1101;  3'd5: return 4'b1010;
            3'd6: return 4'b0110;  default: return 4'b1110;
        endcase
    endfunction

    // 3b/4b control code for RD- after the 6b sub-block; RD+ is always the complement.
    function automatic logic [3:0] code4k_rdm(input logic [2:0] y);
        case (y)
            3'd0: return 4'b1011;  3'd1: return 4'b0110;
            3'd2: return 4'b1010;  3'd3: return 4'b1100;
            3'd4: return 4'b1101;  3'd5: return 4'b0101;
            3'd6: return 4'b1001;  default: return 4'b0111;
        endcase
    endfunction

    // K28.y, K23.7, K27.7, K29.7, K30.7.
    function automatic logic k_legal(input logic [7:0] oct);
        return (oct[4:0] == 5'd28) ||
               (oct == 8'hF7) || (oct == 8'hFB) || (oct == 8'hFD) || (oct == 8'hFE);
    endfunction

    // Returns {disparity flip, 10-bit symbol} for one octet at a given starting RD.
    function automatic logic [10:0] encode(input logic [7:0] oct, input logic is_k,
                                           input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] b6;
        logic [5:0] c6;
        logic [3:0] b4;
        logic [3:0] c4;
        logic       u6;
        logic       u4;
        logic       rd_mid;
        logic       a7;
        x = oct[4:0];
        y = oct[7:5];
        a7 = 1'b0;
        // Illegal control octets are replaced by K28.7.
        if (is_k && !k_legal(oct)) begin
            x = 5'd28;
            y = 3'd7;
        end
        b6 = (is_k && (x == 5'd28)) ? 6'b001111 : code6_rdm(x);
        u6 = ($countones(b6) != 3);
        // D.7 is balanced yet RD-dependent.
        c6 = (rd && (u6 || (b6 == 6'b111000))) ? ~b6 : b6;
        rd_mid = rd ^ u6;
        if (is_k) begin
            b4 = code4k_rdm(y);
            c4 = rd_mid ? ~b4 : b4;
        end else begin
            // A7 avoids a run of five identical bits across the sub-block boundary.
            a7 = rd_mid ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                        : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20));
            b4 = ((y == 3'd7) && a7) ? 4'b0111 : code4d_rdm(y);
            c4 = (rd_mid && (($countones(b4) != 2) || (y == 3'd3))) ? ~b4 : b4;
        end
        u4 = ($countones(c4) != 2);
        return {u6 ^ u4, c6, c4};
    endfunction

    logic          s1_valid;
    logic [DW-1:0] s1_data;
    logic [OCTETS-1:0] s1_k;
    logic          s1_rd_load;
    logic          s1_rd_value;

    logic [10:0]   cand_n [OCTETS];
    logic [10:0]   cand_p [OCTETS];
    logic [OCTETS-1:0] kerr_nxt;
    logic [SW-1:0] data_nxt;
    logic          rd_nxt;
    logic          rd_run;

    // Stage 1: input register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_k        <= '0;
            s1_rd_load  <= 1'b0;
            s1_rd_value <= 1'b0;
        end else begin
            s1_valid    <= i_valid;
            s1_data     <= i_data;
            s1_k        <= i_k;
            s1_rd_load  <= i_rd_load;
            s1_rd_value <= i_rd_value;
        end
    end

    // Per-octet candidates for both starting disparities.
    always_comb begin
        kerr_nxt = '0;
        for (int n = 0; n < int'(OCTETS); n++) begin
            cand_n[n]   = encode(s1_data[8*n +: 8], s1_k[n], 1'b0);
            cand_p[n]   = encode(s1_data[8*n +: 8], s1_k[n], 1'b1);
            kerr_nxt[n] = s1_k[n] & ~k_legal(s1_data[8*n +: 8]);
        end
    end

    // Resolve the RD chain, octet 0 first.
    always_comb begin
        data_nxt = '0;
        rd_run   = s1_rd_load ? s1_rd_value : o_rd;
        for (int n = 0; n < int'(OCTETS); n++) begin
            if (rd_run) begin
                data_nxt[10*n +: 10] = cand_p[n][9:0];
                rd_run = rd_run ^ cand_p[n][10];
            end else begin
                data_nxt[10*n +: 10] = cand_n[n][9:0];
                rd_run = rd_run ^ cand_n[n][10];
            end
        end
        rd_nxt = rd_run;
    end

    // Stage 2: output register; bubbles hold data and only honour an RD load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid   <= 1'b0;
            o_data    <= {OCTETS{10'h274}};
            o_k_error <= '0;
            o_rd      <= RD_INIT;
        end else begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data    <= data_nxt;
                o_k_error <= kerr_nxt;
                o_rd      <= rd_nxt;
            end else if (s1_rd_load) begin
                o_rd <= s1_rd_value;
            end
        end
    end

endmodule

// File: tb/tb_enc8b10b_lane.sv
// Directed bench for enc8b10b_lane (OCTETS=4, RD_INIT=0) with an expected-word scoreboard.
module tb_enc8b10b_lane;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic [3:0]  i_k = '0;
    logic        i_rd_load = 1'b0;
    logic        i_rd_value = 1'b0;
    logic        o_valid;
    logic [39:0] o_data;
    logic [3:0]  o_k_error;
    logic        o_rd;

    typedef struct packed {
        logic [39:0] data;
        logic [3:0]  kerr;
        logic        rd;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    logic have_last = 1'b0;
    logic [1:0] vq = 2'b00;
    logic rst_q = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    localparam logic [39:0] RST_DATA = {4{10'h274}};

    always #5 clk = ~clk;

    enc8b10b_lane #(.OCTETS(4), .RD_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_k        (i_k),
        .i_rd_load  (i_rd_load),
        .i_rd_value (i_rd_value),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_k_error  (o_k_error),
        .o_rd       (o_rd)
    );

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k,
                         input logic ld, input logic rv, input logic push,
                         input logic [39:0] ed, input logic [3:0] ek, input logic er);
        exp_t e;
        @(posedge clk);
        #2;
        i_valid    = v;
        i_data     = d;
        i_k        = k;
        i_rd_load  = ld;
        i_rd_value = rv;
        if (push) begin
            e.data = ed;
            e.kerr = ek;
            e.rd   = er;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Two-cycle valid delay line, flushed by reset.
    always @(posedge clk) begin
        rst_q <= rst_n;
        if (!rst_n) vq <= 2'b00;
        else        vq <= {vq[0], i_valid};
    end

    // Output monitor: valid timing, scoreboard pop, hold through bubbles.
    always @(negedge clk) begin
        if (!rst_q) begin
            have_last = 1'b0;
            sb.delete();
        end else begin
            check("o_valid_timing", 40'(o_valid), 40'(vq[1]));
            if (o_valid === 1'b1) begin
                check("sb_has_entry", 40'(sb.size() != 0), 40'(1'b1));
                if (sb.size() != 0) begin
                    last = sb.pop_front();
                    have_last = 1'b1;
                    check("word_data", o_data, last.data);
                    check("word_kerr", 40'(o_k_error), 40'(last.kerr));
                    check("word_rd", 40'(o_rd), 40'(last.rd));
                end
            end else if (have_last) begin
                check("hold_data", o_data, last.data);
                check("hold_kerr", 40'(o_k_error), 40'(last.kerr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 40'(o_valid), 40'(1'b0));
        check("reset_data", o_data, RST_DATA);
        check("reset_kerr", 40'(o_k_error), 40'(4'h0));
        check("reset_rd", 40'(o_rd), 40'(1'b0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // K28.5 x4 alternating disparity
        drive(1, 32'hBCBCBCBC, 4'hF, 0, 0, 1, {10'h305, 10'h0FA, 10'h305, 10'h0FA}, 4'h0, 0);
        // D21.5 neutral, then with RD+ load
        drive(1, 32'hB5B5B5B5, 4'h0, 0, 0, 1, {4{10'h2AA}}, 4'h0, 0);
        drive(1, 32'hB5B5B5B5, 4'h0, 1, 1, 1, {4{10'h2AA}}, 4'h0, 1);
        // Illegal K on octet 0 at RD-
        drive(1, 32'h00000000, 4'h1, 1, 0, 1, {10'h274, 10'h274, 10'h274, 10'h0F8}, 4'h1, 0);
        // D17.7 A7 at RD-, then D0.0 at RD+
        drive(1, 32'h000000F1, 4'h0, 1, 0, 1, {10'h18B, 10'h18B, 10'h18B, 10'h237}, 4'h0, 1);
        // K23.7, illegal K, K27.7, K28.1 at RD-
        drive(1, 32'h3CFB00F7, 4'hF, 1, 0, 1, {10'h0F9, 10'h368, 10'h0F8, 10'h3A8}, 4'h2, 1);
        // Valid pattern 1,0,1,1 with RD carried across the bubble
        drive(1, 32'h000000F1, 4'h0, 0, 0, 1, {10'h274, 10'h274, 10'h274, 10'h231}, 4'h0, 0);
        drive(0, 32'hFFFFFFFF, 4'hF, 0, 0, 0, '0, 4'h0, 0);
        drive(1, 32'h000000BC, 4'h1, 0, 0, 1, {10'h18B, 10'h18B, 10'h18B, 10'h0FA}, 4'h0, 1);
        drive(1, 32'h000000F4, 4'h0, 0, 0, 1, {10'h274, 10'h274, 10'h274, 10'h0B1}, 4'h0, 0);
        // RD load carried by a bubble
        drive(0, 32'h00000000, 4'h0, 1, 1, 0, '0, 4'h0, 0);
        idle(2);
        @(negedge clk);
        check("bubble_load_valid", 40'(o_valid), 40'(1'b0));
        check("bubble_load_rd", 40'(o_rd), 40'(1'b1));

        // Reset with two words in flight
        drive(1, 32'hBCBCBCBC, 4'hF, 1, 1, 0, '0, 4'h0, 0);
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        i_valid    = 1'b1;
        i_data     = 32'h000000F1;
        i_k        = 4'h0;
        i_rd_load  = 1'b0;
        i_rd_value = 1'b0;
        @(posedge clk);
        #2;
        rst_n      = 1'b1;
        i_valid    = 1'b0;
        i_data     = '0;
        @(negedge clk);
        check("flush_valid", 40'(o_valid), 40'(1'b0));
        check("flush_data", o_data, RST_DATA);
        check("flush_kerr", 40'(o_k_error), 40'(4'h0));
        check("flush_rd", 40'(o_rd), 40'(1'b0));
        idle(4);
        @(negedge clk);
        check("post_flush_rd", 40'(o_rd), 40'(1'b0));
        check("post_flush_data", o_data, RST_DATA);
        check("sb_drained", 40'(sb.size()), 40'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/enc8b10b_lane.md
Name: enc8b10b_lane

Overview:
- Parametrised, pipelined 8b/10b encoder. Successor to the single-octet RD- lookup.
- Encodes OCTETS octets per clock, D or K per octet, with full running-disparity (RD) tracking chained across octets and across cycles.
- Sits between the JESD204B link-layer octet source and the serialiser. One word per clock throughput.

Parameters:
- OCTETS, 4, octets encoded per clock. Range 1..8.
- RD_INIT, 0, running disparity after reset. 0 = RD-, 1 = RD+.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- i_valid  input  1  input word valid.
- i_data  input  8*OCTETS  octets. Octet n is i_data[8n+7:8n], bit order HGFEDCBA (A = LSB). Octet 0 is transmitted first.
- i_k  input  OCTETS  per-octet K flag. 1 = control character, 0 = data.
- i_rd_load  input  1  force RD chain start value for the word in the same cycle.
- i_rd_value  input  1  RD value applied with i_rd_load. 0 = RD-.
- o_valid  output  1  output word valid.
- o_data  output  10*OCTETS  symbols. Symbol n is o_data[10n+9:10n], bit order abcdeifghj (a = MSB).
- o_k_error  output  OCTETS  1 = octet flagged K but not a legal K character.
- o_rd  output  1  RD after the last emitted symbol.

Behaviour:
- Reset (rst_n low at clk edge; wins over all other inputs):
  - o_valid=0, o_k_error=0, o_rd=RD_INIT.
  - Every o_data symbol = 10'h274 (D0.0 RD-).
  - Both pipeline stages flushed; in-flight words are discarded, never emitted.
- Pipeline, latency 2 clocks from i_valid to o_valid:
  - Stage 1: register i_data, i_k, i_valid, i_rd_load, i_rd_value. Per octet, compute both RD- and RD+ candidate codes plus a per-candidate disparity-flip bit.
  - Stage 2: resolve the RD chain octet 0 to OCTETS-1, then register o_data, o_k_error, o_valid, o_rd.
- RD chain:
  - Start value = stage-1 load tag ? stored i_rd_value : o_rd.
  - Octet n uses the RD left by octet n-1. o_rd = RD after octet OCTETS-1.
- Bubbles:
  - A load tag with valid=0 still updates o_rd to the loaded value.
  - Otherwise, when valid=0: o_valid=0, o_data and o_k_error hold their previous values, o_rd unchanged.
- Data codes: IEEE 802.3 Clause 36 5b/6b and 3b/4b tables.
  - The 3b/4b RD is the RD after the 6b sub-block.
  - D.x.P7 vs D.x.A7: use A7 (RD- 0111, RD+ 1000) when RD- and x in {17,18,20}, or RD+ and x in {11,13,14}. Use P7 otherwise.
- Legal K characters: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7, encoded from the standard K table for the current RD.
- Illegal K (i_k=1, octet not in the legal list):
  - Emit K28.7 for the current RD (RD- 10'h0F8, RD+ 10'h307). Both are neutral, so RD is unchanged.
  - Set that octet's o_k_error bit for that word only.
- RD update per symbol: RD flips when the symbol is unbalanced (6 or 4 ones). Neutral symbols leave RD unchanged.
- No backpressure: an input accepted every cycle is emitted exactly 2 cycles later.

Test Plan:
1. Reset, OCTETS=4, RD_INIT=0. Drive i_data=32'hBCBCBCBC, i_k=4'hF, i_valid=1 for 1 cycle -> 2 cycles later o_valid=1 for 1 cycle, symbols 0..3 = 0x0FA, 0x305, 0x0FA, 0x305, o_rd=0, o_k_error=0.
2. Drive i_data=32'hB5B5B5B5 (D21.5), i_k=0, at RD- -> all symbols 0x2AA, o_rd stays 0. Repeat with i_rd_load=1, i_rd_value=1 -> all symbols 0x2AA, o_rd=1.
3. Drive octet0=0x00 with i_k=4'h1, others D0.0, at RD- -> o_k_error=4'h1, symbol0=0x0F8, symbols 1..3=0x274, o_rd=0.
4. Drive i_rd_load=1, i_rd_value=0, octet0=0xF1 (D17.7) -> symbol0=0x237 (A7). RD after octet0 is RD+, so octet1 D0.0 -> 0x18B.
5. Drive i_valid pattern 1,0,1,1 with distinct words -> o_valid pattern 1,0,1,1 delayed 2 clocks; o_data holds through the bubble; RD continuity is correct across the bubble.
6. Drive two valid words in flight, then rst_n=0 for 1 cycle -> next cycle o_valid=0, all symbols 0x274, o_rd=RD_INIT. Neither in-flight word ever appears on the output.
